// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, R-type functs, ALU-op codes, memory sizes
// and the control bundle produced by the ID stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_LUI = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef struct packed {
    logic       mem_to_reg;
    logic       write_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       is_signed;
    logic [1:0] size;
    logic       reg_dest;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       jump;
    logic       link;
  } ctrl_t;

  // Load/store opcodes encode the access width in their two low bits.
  function automatic logic [1:0] ls_size(input logic [5:0] op);
    case (op[1:0])
      2'b00:   ls_size = SIZE_BYTE;
      2'b01:   ls_size = SIZE_HALF;
      default: ls_size = SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational MIPS decode of opcode/funct into the ID control bundle,
// plus an illegal flag and whether rt is read as a source.
module instr_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        uses_rt,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd
);
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    uses_rt = 1'b0;
    rd      = instr[15:11];
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dest  = 1'b1;
        ctrl.write_reg = 1'b1;
        ctrl.alu_op    = ALU_R;
        uses_rt        = 1'b1;
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ;
          FN_JR: begin
            ctrl.jump      = 1'b1;
            ctrl.write_reg = 1'b0;
          end
          FN_JALR: begin
            ctrl.jump = 1'b1;
            ctrl.link = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.write_reg = 1'b1;
        rd             = 5'd31;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
        uses_rt     = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.write_reg = 1'b1;
        ctrl.alu_src   = 1'b1;
        case (opcode)
          OP_SLTI, OP_SLTIU: ctrl.alu_op = ALU_SLT;
          OP_ANDI:           ctrl.alu_op = ALU_AND;
          OP_ORI:            ctrl.alu_op = ALU_OR;
          OP_XORI:           ctrl.alu_op = ALU_XOR;
          OP_LUI:            ctrl.alu_op = ALU_LUI;
          default:           ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.write_reg  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.size       = ls_size(opcode);
        ctrl.is_signed  = ~opcode[2];
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.size      = ls_size(opcode);
        uses_rt        = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_control_stage.sv
// ID stage: registers decoded control, detects load-use hazards against the
// instruction in ID/EX, and tracks a sticky illegal flag and a stall counter.
module decode_control_stage
  import mips_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [WIDTH-1:0]      i_instruction,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic                  i_halt,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic                  o_WB_mem_to_reg,
  output logic                  o_WB_write_reg,
  output logic                  o_MEM_mem_read,
  output logic                  o_MEM_mem_write,
  output logic                  o_MEM_branch,
  output logic                  o_MEM_signed,
  output logic [1:0]            o_MEM_size,
  output logic                  o_EX_reg_dest,
  output logic                  o_EX_ALU_src,
  output logic [ALU_OP_W-1:0]   o_EX_ALU_op,
  output logic                  o_jump,
  output logic                  o_link,
  output logic [REG_ADDR_W-1:0] o_rs,
  output logic [REG_ADDR_W-1:0] o_rt,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  o_illegal,
  output logic [CNT_W-1:0]      o_stall_count
);
  ctrl_t                 dec_ctrl;
  logic                  dec_illegal;
  logic                  dec_uses_rt;
  logic [4:0]            dec_rs;
  logic [4:0]            dec_rt;
  logic [4:0]            dec_rd;
  ctrl_t                 ctrl_q;
  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  illegal_q;
  logic [CNT_W-1:0]      stall_count_q;
  logic                  hazard;
  logic                  stall;

  instr_decoder u_decoder (
    .instr   (i_instruction[31:0]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .uses_rt (dec_uses_rt),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .rd      (dec_rd)
  );

  assign hazard = valid_q && ctrl_q.mem_read && (rt_q != '0) && i_valid &&
                  ((rt_q == REG_ADDR_W'(dec_rs)) ||
                   (dec_uses_rt && (rt_q == REG_ADDR_W'(dec_rt))));
  // A flush redirects the PC, so it must never be held by a stall at the same time.
  assign stall  = hazard && !i_halt && !i_flush;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q        <= '0;
      valid_q       <= 1'b0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      illegal_q     <= 1'b0;
      stall_count_q <= '0;
    end else if (i_flush || (!i_halt && (stall || !i_valid || dec_illegal))) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      if (!i_flush && stall && (stall_count_q != '1))
        stall_count_q <= stall_count_q + 1'b1;
      if (!i_flush && !stall && i_valid && dec_illegal)
        illegal_q <= 1'b1;
    end else if (!i_halt) begin
      ctrl_q  <= dec_ctrl;
      valid_q <= 1'b1;
      rs_q    <= REG_ADDR_W'(dec_rs);
      rt_q    <= REG_ADDR_W'(dec_rt);
      rd_q    <= REG_ADDR_W'(dec_rd);
    end
  end

  assign o_stall         = stall;
  assign o_valid         = valid_q;
  assign o_WB_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_WB_write_reg  = ctrl_q.write_reg;
  assign o_MEM_mem_read  = ctrl_q.mem_read;
  assign o_MEM_mem_write = ctrl_q.mem_write;
  assign o_MEM_branch    = ctrl_q.branch;
  assign o_MEM_signed    = ctrl_q.is_signed;
  assign o_MEM_size      = ctrl_q.size;
  assign o_EX_reg_dest   = ctrl_q.reg_dest;
  assign o_EX_ALU_src    = ctrl_q.alu_src;
  assign o_EX_ALU_op     = ALU_OP_W'(ctrl_q.alu_op);
  assign o_jump          = ctrl_q.jump;
  assign o_link          = ctrl_q.link;
  assign o_rs            = rs_q;
  assign o_rt            = rt_q;
  assign o_rd            = rd_q;
  assign o_illegal       = illegal_q;
  assign o_stall_count   = stall_count_q;

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed bench for decode_control_stage with hand-computed expectations;
// a narrow stall counter keeps the saturation run short.
module tb_decode_control_stage;
  localparam int CNT_W = 4;

  logic             clk_sys = 1'b0;
  logic             i_reset;
  logic [31:0]      i_instruction;
  logic             i_valid, i_flush, i_halt;
  logic             o_stall, o_valid;
  logic             o_WB_mem_to_reg, o_WB_write_reg;
  logic             o_MEM_mem_read, o_MEM_mem_write, o_MEM_branch, o_MEM_signed;
  logic [1:0]       o_MEM_size;
  logic             o_EX_reg_dest, o_EX_ALU_src;
  logic [2:0]       o_EX_ALU_op;
  logic             o_jump, o_link;
  logic [4:0]       o_rs, o_rt, o_rd;
  logic             o_illegal;
  logic [CNT_W-1:0] o_stall_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  decode_control_stage #(.WIDTH(32), .REG_ADDR_W(5), .ALU_OP_W(3), .CNT_W(CNT_W)) dut (
    .i_clk(clk_sys), .i_reset(i_reset), .i_instruction(i_instruction),
    .i_valid(i_valid), .i_flush(i_flush), .i_halt(i_halt), .o_stall(o_stall),
    .o_valid(o_valid), .o_WB_mem_to_reg(o_WB_mem_to_reg), .o_WB_write_reg(o_WB_write_reg),
    .o_MEM_mem_read(o_MEM_mem_read), .o_MEM_mem_write(o_MEM_mem_write),
    .o_MEM_branch(o_MEM_branch), .o_MEM_signed(o_MEM_signed), .o_MEM_size(o_MEM_size),
    .o_EX_reg_dest(o_EX_reg_dest), .o_EX_ALU_src(o_EX_ALU_src), .o_EX_ALU_op(o_EX_ALU_op),
    .o_jump(o_jump), .o_link(o_link), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_illegal(o_illegal), .o_stall_count(o_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
    r_ins = {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt);
    i_ins = {op, rs[4:0], rt[4:0], 16'h0004};
  endfunction

  localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LH = 6'b100001, LBU = 6'b100100;
  localparam logic [5:0] SW = 6'b101011, ADDI = 6'b001000, JAL = 6'b000011;
  localparam logic [5:0] ADDU = 6'b100001;

  initial begin
    i_reset = 1'b1; i_instruction = '0; i_valid = 1'b0; i_flush = 1'b0; i_halt = 1'b0;
    #3;
    chk("rst_valid", o_valid, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_illegal", o_illegal, 0);
    chk("rst_count", o_stall_count, 0);
    @(negedge clk_sys);
    i_reset = 1'b0;

    // LW $9,4($8) followed by dependent ADDU $10,$9,$11
    i_valid = 1'b1; i_instruction = i_ins(LW, 8, 9);
    tick();
    chk("lw_valid", o_valid, 1);
    chk("lw_ctrl", {o_MEM_mem_read, o_WB_mem_to_reg, o_WB_write_reg, o_EX_ALU_src, o_MEM_size}, 6'b111111);
    chk("lw_rt", o_rt, 9);
    i_instruction = r_ins(9, 11, 10, ADDU);
    #1;
    chk("lu_stall", o_stall, 1);
    tick();
    chk("lu_bubble_valid", o_valid, 0);
    chk("lu_bubble_rd", o_MEM_mem_read, 0);
    chk("lu_count1", o_stall_count, 1);
    chk("lu_stall_clear", o_stall, 0);
    tick();
    chk("addu_valid", o_valid, 1);
    chk("addu_ctrl", {o_EX_reg_dest, o_WB_write_reg, o_EX_ALU_op, o_EX_ALU_src}, 6'b110100);
    chk("addu_rd", o_rd, 10);

    // load to $0 never stalls
    i_instruction = i_ins(LW, 8, 0);
    tick();
    i_instruction = r_ins(0, 0, 10, ADDU);
    #1;
    chk("zero_stall", o_stall, 0);
    tick();
    chk("zero_count", o_stall_count, 1);

    // store reads rt -> hazard; ADDI writes rt -> no hazard
    i_instruction = i_ins(LW, 8, 9);
    tick();
    i_instruction = i_ins(ADDI, 8, 9);
    #1;
    chk("addi_rt_nostall", o_stall, 0);
    i_instruction = i_ins(SW, 8, 9);
    #1;
    chk("sw_rt_stall", o_stall, 1);
    i_halt = 1'b1;
    #1;
    chk("halt_kills_stall", o_stall, 0);
    tick();
    chk("halt_holds", {o_valid, o_MEM_mem_read, o_rt}, {2'b11, 5'd9});
    chk("halt_count", o_stall_count, 1);
    i_halt = 1'b0;
    tick();
    chk("sw_count2", o_stall_count, 2);
    tick();
    chk("sw_ctrl", {o_valid, o_MEM_mem_write, o_WB_write_reg, o_MEM_size}, 5'b11011);

    // LBU / LH size and sign
    i_instruction = i_ins(LBU, 1, 2);
    tick();
    chk("lbu", {o_MEM_size, o_MEM_signed, o_MEM_mem_read, o_WB_mem_to_reg, o_EX_ALU_op}, 8'b00011000);
    i_instruction = i_ins(LH, 1, 2);
    tick();
    chk("lh", {o_MEM_size, o_MEM_signed}, 3'b011);
    i_instruction = i_ins(LB, 1, 2);
    tick();
    chk("lb", {o_MEM_size, o_MEM_signed}, 3'b001);

    // JAL, then JAL with flush
    i_instruction = {JAL, 26'h0000100};
    tick();
    chk("jal", {o_valid, o_jump, o_link, o_WB_write_reg, o_rd}, {4'b1111, 5'd31});
    i_flush = 1'b1;
    tick();
    chk("flush", {o_valid, o_jump, o_link, o_WB_write_reg, o_rd}, 9'd0);
    i_flush = 1'b0;

    // i_valid low gives a bubble
    i_instruction = r_ins(1, 2, 3, ADDU);
    tick();
    i_valid = 1'b0;
    tick();
    chk("invalid_bubble", {o_valid, o_WB_write_reg}, 0);
    i_valid = 1'b1;

    // illegal opcode, sticky until reset
    i_instruction = 32'hFC00_0000;
    tick();
    chk("ill_bubble", o_valid, 0);
    chk("ill_flag", o_illegal, 1);
    i_instruction = r_ins(1, 2, 3, ADDU);
    tick();
    chk("ill_sticky", {o_illegal, o_valid, o_rd}, {2'b11, 5'd3});
    #2;
    i_reset = 1'b1;
    #1;
    chk("midrst", {o_valid, o_illegal, o_WB_write_reg, o_EX_reg_dest, o_rd, o_stall_count}, 0);
    i_reset = 1'b0;
    tick();
    chk("post_rst_load", {o_valid, o_rd}, {1'b1, 5'd3});

    // illegal R-type funct
    i_instruction = r_ins(1, 2, 3, 6'b111111);
    tick();
    chk("ill_funct", {o_illegal, o_valid}, 2'b10);

    // reset mid-stall
    i_instruction = i_ins(LW, 8, 9);
    tick();
    i_instruction = r_ins(4, 9, 5, ADDU);
    #1;
    chk("pre_rst_stall", o_stall, 1);
    i_reset = 1'b1;
    #1;
    chk("rst_stall_low", {o_stall, o_valid}, 0);
    i_reset = 1'b0;
    tick();
    chk("rst_resume", {o_valid, o_rd, o_stall_count}, {1'b1, 5'd5, 4'd0});

    // saturation: 2^CNT_W + 3 load-use stalls
    for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
      i_instruction = i_ins(LW, 8, 9);
      tick();
      i_instruction = r_ins(9, 0, 10, ADDU);
      tick();
    end
    chk("sat_count", o_stall_count, (1 << CNT_W) - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_control_stage.md
DECODE_CONTROL_STAGE -- requirements
Module: decode_control_stage

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- WIDTH, 32, instruction width
- REG_ADDR_W, 5, register-address width
- ALU_OP_W, 3, ALU-op code width
- CNT_W, 16, stall-counter width
REQ-002 Clocking SHALL be one clock, i_clk; reset SHALL be i_reset, asynchronous, active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
- i_clk, in, 1, clock
- i_reset, in, 1, async active-high reset
- i_instruction, in, WIDTH, IF/ID instruction
- i_valid, in, 1, instruction valid
- i_flush, in, 1, branch/jump taken: squash
- i_halt, in, 1, freeze stage
- o_stall, out, 1, load-use hazard: hold PC and IF/ID
- o_valid, out, 1, registered bundle valid
- o_WB_mem_to_reg, out, 1, WB control
- o_WB_write_reg, out, 1, WB control
- o_MEM_mem_read, out, 1, MEM control
- o_MEM_mem_write, out, 1, MEM control
- o_MEM_branch, out, 1, MEM control
- o_MEM_signed, out, 1, MEM control
- o_MEM_size, out, 2, 00 byte / 01 half / 11 word
- o_EX_reg_dest, out, 1, EX control
- o_EX_ALU_src, out, 1, EX control
- o_EX_ALU_op, out, ALU_OP_W, EX control
- o_jump, out, 1, jump indication
- o_link, out, 1, write return address
- o_rs, out, REG_ADDR_W, source register
- o_rt, out, REG_ADDR_W, source register
- o_rd, out, REG_ADDR_W, destination register
- o_illegal, out, 1, sticky unknown-opcode flag
- o_stall_count, out, CNT_W, load-use stalls seen

Function
REQ-004 Decode SHALL be combinational on opcode [31:26] and funct [5:0]; every output SHALL be registered on the rising i_clk edge (latency 1 cycle).
REQ-005 ALU op encoding:
- 000 add: loads, stores, ADDI, ADDIU
- 001 sub: BEQ, BNE
- 010 R-type (funct decides)
- 011 and: ANDI
- 100 or: ORI
- 101 xor: XORI
- 110 LUI
- 111 slt: SLTI, SLTIU
REQ-006 Load/store size and signedness:
- LB, SB: size 00
- LH, SH: size 01
- LW, LWU, SW: size 11
- LB, LH: signed=1; LBU, LHU, LWU: signed=0
REQ-007 R-type SHALL set reg_dest=1, write_reg=1; JR SHALL set jump=1, write_reg=0; JALR SHALL set jump=1, link=1, write_reg=1.
REQ-008 J SHALL set jump=1; JAL SHALL set jump=1, link=1, write_reg=1, with rd forced to 31.
REQ-009 Load-use hazard: o_stall SHALL be combinational, 1 when all of the following hold:
- o_valid=1 and o_MEM_mem_read=1
- o_rt!=0
- o_rt equals the incoming rs, or equals the incoming rt for R-type, stores and branches
- i_valid=1
REQ-010 On stall the stage SHALL load a bubble: all control 0, o_valid=0. The hazard then clears the following cycle, so a stall lasts exactly one cycle per load-use pair.
REQ-011 Update priority SHALL be reset > i_flush > i_halt > stall > normal load. i_flush loads a bubble. i_halt holds all registers and forces o_stall=0.
REQ-012 i_valid=0 SHALL load a bubble.
REQ-013 An unknown opcode or R-type funct with i_valid=1 SHALL load a bubble and set o_illegal=1 until reset.
REQ-014 o_stall_count SHALL increment once per stall cycle and saturate at all-ones, with no wrap.

Reset
REQ-015 Asserting i_reset SHALL clear every registered output to 0 immediately, regardless of i_clk. This includes o_valid, o_illegal and o_stall_count.
REQ-016 Reset asserted mid-stall SHALL leave o_stall=0 once o_valid clears, and normal loading SHALL resume on the first edge after deassertion.

Structure
REQ-017 Opcode, funct and ALU-op constants and the size codes SHALL live in a shared package, mips_pkg, reused by the EX-stage ALU control.
REQ-018 Combinational decode SHALL be one sub-module, instr_decoder; hazard detection, pipeline registers and the counter SHALL stay in the top.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- LW $t1,0($t0) then ADDU $t2,$t1,$t3 -> o_stall=1 for one cycle, then a bubble with o_valid=0, then ADDU valid; o_stall_count=1.
- LW to $0 followed by a read of $0 -> o_stall=0, o_stall_count unchanged.
- LBU -> size=00, signed=0, mem_read=1, mem_to_reg=1, ALU_op=000; LH -> size=01, signed=1.
- JAL -> jump=1, link=1, o_rd=31, write_reg=1; i_flush in the same cycle -> bubble only.
- Opcode 6'b111111 -> bubble, o_illegal=1 until i_reset; i_reset mid-cycle -> all outputs 0 before the next edge.
- Force 2^CNT_W+3 load-use stalls -> o_stall_count saturates at all-ones.
